// File: rtl/ipsxe_floating_point_result_checker.sv
// Floating-point result checker for the example design.
// DUT results are captured in a small FIFO and compared in order against
// the golden ROM, which has a registered output and one cycle of latency.
// The checker reports a mismatch count, the first failing index, a timeout
// and an overflow.
// Optional build macro: IPSXE_FLOATING_POINT_CHECKER_NAN_RELAX_EN. When it is
// defined and OP_SEL selects a float operation, any two NaNs compare equal.
module ipsxe_floating_point_result_checker #(
  parameter int EXP_WIDTH      = 8,
  parameter int MAN_WIDTH      = 23,
  parameter int OP_SEL         = 0,
  parameter int NUM_VECTORS    = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           dut_valid,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]   dut_result,
  output logic [3:0]                     rom_rd_addr,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]   rom_dout,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [4:0]                     err_cnt,
  output logic [3:0]                     first_err_addr,
  output logic                           timeout,
  output logic                           overflow
);

  localparam int unsigned W       = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]    LAST_IDX = 4'(NUM_VECTORS - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_ONE   = TW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);

  if (NUM_VECTORS < 1 || NUM_VECTORS > 16) begin : g_bad_num_vectors
    $error("NUM_VECTORS must be in 1..16");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("FIFO_DEPTH must be a power of two in 2..16");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  if (OP_SEL < 0) begin : g_bad_op_sel
    $error("OP_SEL must be non-negative");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LAT,
    S_CMP,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  logic [W-1:0]    r_cmp;
  logic [3:0]      r_idx;
  logic [4:0]      r_err_cnt;
  logic [3:0]      r_first_err;
  logic            r_timeout;
  logic            r_overflow;
  logic [TW-1:0]   r_to_cnt;

  logic            w_busy;
  logic            w_empty;
  logic            w_full;
  logic            w_start_ok;
  logic            w_push;
  logic            w_pop;
  logic            w_to_hit;
  logic            w_last;
  logic            w_match;

  assign w_busy     = (r_state == S_FETCH) || (r_state == S_LAT) || (r_state == S_CMP);
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_push     = w_busy && dut_valid && !w_full;
  assign w_pop      = (r_state == S_FETCH) && !w_empty;
  assign w_to_hit   = (r_state == S_FETCH) && w_empty && (r_to_cnt == TO_LAST);
  assign w_last     = (r_idx == LAST_IDX);

`ifdef IPSXE_FLOATING_POINT_CHECKER_NAN_RELAX_EN
  localparam bit FLOAT_OP = !((OP_SEL == 3) || (OP_SEL == 6) || (OP_SEL == 7));
  logic w_cmp_nan;
  logic w_rom_nan;
  assign w_cmp_nan = (&r_cmp[W-2 -: EXP_WIDTH])    && (|r_cmp[MAN_WIDTH-1:0]);
  assign w_rom_nan = (&rom_dout[W-2 -: EXP_WIDTH]) && (|rom_dout[MAN_WIDTH-1:0]);
  assign w_match   = (r_cmp == rom_dout) || (FLOAT_OP && w_cmp_nan && w_rom_nan);
`else
  assign w_match   = (r_cmp == rom_dout);
`endif

  assign rom_rd_addr    = r_idx;
  assign busy           = w_busy;
  assign done           = (r_state == S_DONE);
  assign pass           = done && (r_err_cnt == '0) && !r_timeout && !r_overflow;
  assign err_cnt        = r_err_cnt;
  assign first_err_addr = r_first_err;
  assign timeout        = r_timeout;
  assign overflow       = r_overflow;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_FETCH;
      S_FETCH: begin
        if (!w_empty)     w_next = S_LAT;
        else if (w_to_hit) w_next = S_DONE;
      end
      S_LAT:   w_next = S_CMP;
      S_CMP:   w_next = w_last ? S_DONE : S_FETCH;
      default: w_next = S_IDLE;
    endcase
  end

  // Capture FIFO storage; emptiness is tracked by the pointers alone
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= dut_result;
  end

  // Run bookkeeping: pointers, vector index, error tracking, sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cmp       <= '0;
      r_idx       <= '0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
      r_timeout   <= 1'b0;
      r_overflow  <= 1'b0;
      r_to_cnt    <= '0;
    end else if (w_start_ok) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_idx       <= '0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
      r_timeout   <= 1'b0;
      r_overflow  <= 1'b0;
      r_to_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_busy && dut_valid && w_full) r_overflow <= 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_cmp    <= r_mem[r_rd_ptr[AW-1:0]];
        r_to_cnt <= '0;
      end else if (r_state == S_FETCH) begin
        if (w_to_hit) r_timeout <= 1'b1;
        else          r_to_cnt  <= r_to_cnt + TO_ONE;
      end
      if (r_state == S_CMP) begin
        if (!w_match) begin
          if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 5'd1;
          if (r_err_cnt == '0) r_first_err <= r_idx;
        end
        if (!w_last) r_idx <= r_idx + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_ipsxe_floating_point_result_checker.sv
// Directed bench for the floating-point result checker: a table of whole
// runs plus hand-written sequences for burst/overflow, timeout, reset
// mid-run and start handling.
module tb_ipsxe_floating_point_result_checker;

  localparam int NV = 4;
  localparam int FD = 4;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        dut_valid;
  logic [31:0] dut_result;
  logic [3:0]  rom_rd_addr;
  logic [31:0] rom_dout;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  err_cnt;
  logic [3:0]  first_err_addr;
  logic        timeout;
  logic        overflow;

  ipsxe_floating_point_result_checker #(
    .EXP_WIDTH(8),
    .MAN_WIDTH(23),
    .OP_SEL(0),
    .NUM_VECTORS(NV),
    .FIFO_DEPTH(FD),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dut_valid(dut_valid),
    .dut_result(dut_result),
    .rom_rd_addr(rom_rd_addr),
    .rom_dout(rom_dout),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_cnt(err_cnt),
    .first_err_addr(first_err_addr),
    .timeout(timeout),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Golden ROM model with registered output
  logic [31:0] golden [16];
  always @(posedge clk) rom_dout <= golden[rom_rd_addr];

  int checks = 0;
  int errors = 0;

  // Distinct ROM addresses seen while busy, in order
  logic [3:0] addr_log [$];
  always @(negedge clk)
    if (busy && (addr_log.size() == 0 || addr_log[$] != rom_rd_addr))
      addr_log.push_back(rom_rd_addr);

  typedef struct {
    logic [3:0][31:0] v;
    int               gap;
    logic [4:0]       err;
    logic [3:0]       first;
    logic             pass;
  } run_t;

  run_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic run_t mk(input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] a3,
                              input int gap, input logic [4:0] err,
                              input logic [3:0] first, input logic p);
    run_t r;
    r.v[0] = a0; r.v[1] = a1; r.v[2] = a2; r.v[3] = a3;
    r.gap = gap; r.err = err; r.first = first; r.pass = p;
    return r;
  endfunction

  task automatic do_start();
    addr_log.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_one(input logic [31:0] v, input int gap);
    dut_valid = 1'b1;
    dut_result = v;
    @(negedge clk);
    dut_valid = 1'b0;
    for (int k = 1; k < gap; k++) @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, done, 1'b1);
  endtask

  task automatic check_end(input string tag, input logic [4:0] err, input logic [3:0] first,
                           input logic p, input logic to, input logic ov);
    check({tag, "_err_cnt"}, err_cnt, err);
    check({tag, "_first_err"}, first_err_addr, first);
    check({tag, "_pass"}, pass, p);
    check({tag, "_timeout"}, timeout, to);
    check({tag, "_overflow"}, overflow, ov);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic check_addr_log(input string tag);
    check({tag, "_addr_count"}, addr_log.size(), NV);
    for (int i = 0; i < NV && i < addr_log.size(); i++)
      check({tag, "_addr_step"}, addr_log[i], i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] g [4];
    g[0] = 32'h4080_0000;
    g[1] = 32'h7FC0_0000;
    g[2] = 32'h7F80_0000;
    g[3] = 32'h0000_0000;
    for (int i = 0; i < 16; i++) golden[i] = (i < 4) ? g[i] : 32'h0;

    tbl[0] = mk(g[0], g[1], g[2], g[3], 5, 5'd0, 4'd0, 1'b1);
    tbl[1] = mk(g[0], g[1], 32'h7F80_0001, g[3], 5, 5'd1, 4'd2, 1'b0);
`ifdef IPSXE_FLOATING_POINT_CHECKER_NAN_RELAX_EN
    tbl[2] = mk(g[0], 32'hFFC0_0001, g[2], g[3], 5, 5'd0, 4'd0, 1'b1);
`else
    tbl[2] = mk(g[0], 32'hFFC0_0001, g[2], g[3], 5, 5'd1, 4'd1, 1'b0);
`endif
    tbl[3] = mk(g[0], g[1], g[2], g[3], 1, 5'd0, 4'd0, 1'b1);
    tbl[4] = mk(g[0], 32'h3F80_0000, g[2], 32'h8000_0000, 3, 5'd2, 4'd1, 1'b0);
    tbl[5] = mk(g[0], g[1], 32'hFF80_0000, g[3], 2, 5'd1, 4'd2, 1'b0);

    rst = 1'b1; start = 1'b0; dut_valid = 1'b0; dut_result = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_pass", pass, 1'b0);
    check("reset_err_cnt", err_cnt, 5'd0);
    check("reset_addr", rom_rd_addr, 4'd0);
    check("reset_flags", {timeout, overflow, first_err_addr}, 6'd0);
    rst = 1'b0;

    // dut_valid in IDLE must not reach the FIFO
    send_one(32'hDEAD_BEEF, 2);

    // Table of complete runs
    for (int t = 0; t < 6; t++) begin
      do_start();
      check($sformatf("run%0d_busy_after_start", t), busy, 1'b1);
      for (int i = 0; i < 4; i++) send_one(tbl[t].v[i], tbl[t].gap);
      wait_done($sformatf("run%0d", t), 60, n);
      check_end($sformatf("run%0d", t), tbl[t].err, tbl[t].first, tbl[t].pass, 1'b0, 1'b0);
      check_addr_log($sformatf("run%0d", t));
    end

    // Long burst: FIFO fills after six accepted samples, the seventh overflows
    do_start();
    for (int i = 0; i < 8; i++) send_one(g[i % 4], 1);
    wait_done("ovf", 60, n);
    check_end("ovf", 5'd0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Timeout: no DUT results at all
    do_start();
    wait_done("tmo", 18, n);
    check("tmo_cycles", n, TO);
    check_end("tmo", 5'd0, 4'd0, 1'b0, 1'b1, 1'b0);

    // Reset while vector 1 sits in the ROM latency cycle
    do_start();
    send_one(g[0], 1);
    send_one(g[1], 1);
    repeat (3) @(negedge clk);
    check("rstmid_busy_before", busy, 1'b1);
    check("rstmid_addr_before", rom_rd_addr, 4'd1);
    rst = 1'b1;
    #1;
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_addr", rom_rd_addr, 4'd0);
    check("rstmid_outs", {done, pass, err_cnt, first_err_addr, timeout, overflow}, 13'd0);
    @(negedge clk);
    rst = 1'b0;
    do_start();
    for (int i = 0; i < 4; i++) send_one(g[i], 4);
    wait_done("rstmid_rerun", 60, n);
    check_end("rstmid_rerun", 5'd0, 4'd0, 1'b1, 1'b0, 1'b0);

    // Start while busy is ignored
    do_start();
    send_one(g[0], 5);
    send_one(g[1], 5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busystart_idx", rom_rd_addr, 4'd2);
    send_one(g[2], 5);
    send_one(g[3], 5);
    wait_done("busystart", 60, n);
    check_end("busystart", 5'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    check_addr_log("busystart");

    // Start from DONE clears the previous result
    do_start();
    for (int i = 0; i < 4; i++) send_one((i == 3) ? 32'h0000_0001 : g[i], 5);
    wait_done("redo_a", 60, n);
    check_end("redo_a", 5'd1, 4'd3, 1'b0, 1'b0, 1'b0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("redo_done_cleared", done, 1'b0);
    check("redo_err_cleared", err_cnt, 5'd0);
    check("redo_first_cleared", first_err_addr, 4'd0);
    check("redo_busy", busy, 1'b1);
    for (int i = 0; i < 4; i++) send_one(g[i], 5);
    wait_done("redo_b", 60, n);
    check_end("redo_b", 5'd0, 4'd0, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
